// File: rtl/rx_frame_sequencer.sv
`default_nettype none
// ============================================================================
// rx_frame_sequencer : 802.11a receive-chain control FSM (preamble, SIGNAL
//                      check/decode, payload gating, symbol/pad count, drain)
// Optional: define RX_PARITY_CHECK_EN to enable the SIGNAL parity check.
// Revision: 1.0
// ============================================================================
module rx_frame_sequencer #(
    parameter int PREAMBLE_LEN  = 30,
    parameter int MAX_LEN       = 4095,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx_valid,
    input  logic        rx_bit,
    input  logic        dec_done,
    output logic        payload_bit,
    output logic        payload_valid,
    output logic [1:0]  mode,
    output logic        dec_read_en,
    output logic [34:0] rxvector,
    output logic        hdr_valid,
    output logic        hdr_error,
    output logic [2:0]  hdr_status,
    output logic [10:0] n_sym,
    output logic [9:0]  n_pad,
    output logic        frame_done,
    output logic        frame_abort,
    output logic        busy
);

    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SIGNAL   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PRE_W-1:0]   pre_cnt;
    logic [4:0]         sig_cnt;
    logic [22:0]        sr;
    logic [8:0]         ncbps;
    logic [7:0]         ndbps;
    logic [15:0]        target;
    logic [8:0]         cbit_cnt;
    logic [15:0]        dacc;
    logic [DRN_W-1:0]   drain_cnt;

    logic               accept;
    logic               abort_req;
    logic [23:0]        hdr;
    logic [3:0]         hdr_rate;
    logic [11:0]        hdr_len;
    logic               rate_ok;
    logic [8:0]         rate_ncbps;
    logic [7:0]         rate_ndbps;
    logic [1:0]         rate_mode;
    logic               par_err;
    logic               len_err;
    logic [2:0]         hdr_chk;
    logic               hdr_pass;
    logic               sig_last;
    logic               sym_wrap;
    logic [15:0]        dacc_sum;
    logic               last_bit;
    logic               drain_hit;
    logic               drain_exit;
    logic               drain_tmo;
    logic               unused_hdr;

    assign accept    = enable & rx_valid;
    assign abort_req = enable & ~rx_valid &
                       ((state == ST_PREAMBLE) | (state == ST_SIGNAL) | (state == ST_PAYLOAD));

    // The 24th bit is still on rx_bit; the first 23 sit in sr, LSB-first.
    assign hdr        = {rx_bit, sr};
    assign hdr_rate   = hdr[3:0];
    assign hdr_len    = hdr[16:5];
    assign unused_hdr = ^hdr[23:17];

    always_comb begin
        rate_ok    = 1'b1;
        rate_ncbps = 9'd0;
        rate_ndbps = 8'd0;
        rate_mode  = 2'd0;
        case (hdr_rate)
            4'b1011: begin rate_ncbps = 9'd48;  rate_ndbps = 8'd24;                    end
            4'b1111: begin rate_ncbps = 9'd48;  rate_ndbps = 8'd36;  rate_mode = 2'd1; end
            4'b1010: begin rate_ncbps = 9'd96;  rate_ndbps = 8'd48;                    end
            4'b1110: begin rate_ncbps = 9'd96;  rate_ndbps = 8'd72;  rate_mode = 2'd1; end
            4'b1001: begin rate_ncbps = 9'd192; rate_ndbps = 8'd96;                    end
            4'b1101: begin rate_ncbps = 9'd192; rate_ndbps = 8'd144; rate_mode = 2'd1; end
            4'b1000: begin rate_ncbps = 9'd288; rate_ndbps = 8'd192; rate_mode = 2'd2; end
            4'b1100: begin rate_ncbps = 9'd288; rate_ndbps = 8'd216; rate_mode = 2'd1; end
            default: rate_ok = 1'b0;
        endcase
    end

`ifdef RX_PARITY_CHECK_EN
    assign par_err = ^hdr[17:0];
`else
    assign par_err = 1'b0;
`endif

    assign len_err  = hdr[4] | (hdr_len == 12'd0) | ({20'd0, hdr_len} > 32'(MAX_LEN));
    assign hdr_chk  = {len_err, ~rate_ok, par_err};
    assign hdr_pass = (hdr_chk == 3'b000);

    assign sig_last  = (state == ST_SIGNAL) & accept & (sig_cnt == 5'd23);
    assign sym_wrap  = (state == ST_PAYLOAD) & accept & (cbit_cnt == ncbps - 9'd1);
    assign dacc_sum  = dacc + {8'd0, ndbps};
    // Symbol count and pad fall out of the running data-bit total: no divider.
    assign last_bit  = sym_wrap & (dacc_sum >= target);
    assign drain_hit = (drain_cnt == DRN_W'(DRAIN_TIMEOUT - 1));
    assign drain_exit = (state == ST_DRAIN) & enable & (dec_done | drain_hit);
    assign drain_tmo  = (state == ST_DRAIN) & enable & ~dec_done & drain_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != ST_IDLE);
        dec_read_en = (state == ST_DRAIN);
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (abort_req) state_nxt = ST_IDLE;
                else if (accept && (pre_cnt == PRE_W'(PREAMBLE_LEN - 1))) state_nxt = ST_SIGNAL;
            end
            ST_SIGNAL: begin
                if (abort_req)     state_nxt = ST_IDLE;
                else if (sig_last) state_nxt = hdr_pass ? ST_PAYLOAD : ST_ERROR;
            end
            ST_PAYLOAD: begin
                if (abort_req)     state_nxt = ST_IDLE;
                else if (last_bit) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_exit) state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                if (enable && !rx_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt       <= '0;
            sig_cnt       <= 5'd0;
            sr            <= 23'd0;
            ncbps         <= 9'd0;
            ndbps         <= 8'd0;
            target        <= 16'd0;
            cbit_cnt      <= 9'd0;
            dacc          <= 16'd0;
            drain_cnt     <= '0;
            payload_bit   <= 1'b0;
            payload_valid <= 1'b0;
            mode          <= 2'd0;
            rxvector      <= 35'd0;
            hdr_valid     <= 1'b0;
            hdr_error     <= 1'b0;
            hdr_status    <= 3'b000;
            n_sym         <= 11'd0;
            n_pad         <= 10'd0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
        end else begin
            hdr_valid     <= 1'b0;
            hdr_error     <= 1'b0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
            payload_valid <= 1'b0;

            if (abort_req) begin
                frame_abort <= 1'b1;
                pre_cnt     <= '0;
                sig_cnt     <= 5'd0;
                cbit_cnt    <= 9'd0;
                dacc        <= 16'd0;
                drain_cnt   <= '0;
                n_sym       <= 11'd0;
                n_pad       <= 10'd0;
            end

            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        pre_cnt <= PRE_W'(1);
                        sig_cnt <= 5'd0;
                    end
                    ST_PREAMBLE: begin
                        pre_cnt <= pre_cnt + PRE_W'(1);
                    end
                    ST_SIGNAL: begin
                        sr      <= {rx_bit, sr[22:1]};
                        sig_cnt <= sig_cnt + 5'd1;
                        if (sig_last) begin
                            hdr_status <= hdr_chk;
                            if (hdr_pass) begin
                                hdr_valid <= 1'b1;
                                rxvector  <= {hdr_len, 3'b000, hdr_rate, 16'h0000};
                                mode      <= rate_mode;
                                ncbps     <= rate_ncbps;
                                ndbps     <= rate_ndbps;
                                target    <= 16'd22 + {1'b0, hdr_len, 3'b000};
                                cbit_cnt  <= 9'd0;
                                dacc      <= 16'd0;
                                n_sym     <= 11'd0;
                                n_pad     <= 10'd0;
                            end else begin
                                hdr_error <= 1'b1;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        payload_bit   <= rx_bit;
                        payload_valid <= 1'b1;
                        if (sym_wrap) begin
                            cbit_cnt <= 9'd0;
                            n_sym    <= n_sym + 11'd1;
                            dacc     <= dacc_sum;
                            if (last_bit) begin
                                n_pad     <= 10'(dacc_sum - target);
                                drain_cnt <= '0;
                            end
                        end else begin
                            cbit_cnt <= cbit_cnt + 9'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if ((state == ST_DRAIN) && enable) begin
                drain_cnt <= drain_cnt + DRN_W'(1);
                if (drain_exit) frame_done    <= 1'b1;
                if (drain_tmo)  hdr_status[2] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_sequencer.sv
`default_nettype none
// Self-checking bench for rx_frame_sequencer: table-driven frames, hand-written
// corner sequences, and randomized frames against an arithmetic reference model.
module tb_rx_frame_sequencer;

    localparam int PRE = 30;
    localparam int DRN = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        rx_valid;
    logic        rx_bit;
    logic        dec_done;
    logic        payload_bit;
    logic        payload_valid;
    logic [1:0]  mode;
    logic        dec_read_en;
    logic [34:0] rxvector;
    logic        hdr_valid;
    logic        hdr_error;
    logic [2:0]  hdr_status;
    logic [10:0] n_sym;
    logic [9:0]  n_pad;
    logic        frame_done;
    logic        frame_abort;
    logic        busy;

    rx_frame_sequencer #(
        .PREAMBLE_LEN  (PRE),
        .MAX_LEN       (4095),
        .DRAIN_TIMEOUT (DRN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .rx_valid      (rx_valid),
        .rx_bit        (rx_bit),
        .dec_done      (dec_done),
        .payload_bit   (payload_bit),
        .payload_valid (payload_valid),
        .mode          (mode),
        .dec_read_en   (dec_read_en),
        .rxvector      (rxvector),
        .hdr_valid     (hdr_valid),
        .hdr_error     (hdr_error),
        .hdr_status    (hdr_status),
        .n_sym         (n_sym),
        .n_pad         (n_pad),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] rate;
        int         len;
        bit         resv;
        bit         flip;
        bit         ok;
        logic [2:0] status;
        int         mode;
        int         ncbps;
        int         nsym;
        int         npad;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    logic rx_q[$];
    int   fd_cnt = 0;
    int   fa_cnt = 0;
    logic sent[$];
    int   pv_base;
    int   fd_base;
    int   fa_base;
    vec_t tbl[13];

    // Monitor: collects every forwarded payload bit and every pulse.
    always @(negedge clock) begin
        if (payload_valid) rx_q.push_back(payload_bit);
        if (frame_done)    fd_cnt++;
        if (frame_abort)   fa_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model straight from the rate table and length arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   ndb;
        int   tgt;
        r = v;
        r.status = 3'b000; r.mode = 0; r.ncbps = 0; r.nsym = 0; r.npad = 0; ndb = 0;
        case (v.rate)
            4'b1011: begin r.ncbps = 48;  ndb = 24;  r.mode = 0; end
            4'b1111: begin r.ncbps = 48;  ndb = 36;  r.mode = 1; end
            4'b1010: begin r.ncbps = 96;  ndb = 48;  r.mode = 0; end
            4'b1110: begin r.ncbps = 96;  ndb = 72;  r.mode = 1; end
            4'b1001: begin r.ncbps = 192; ndb = 96;  r.mode = 0; end
            4'b1101: begin r.ncbps = 192; ndb = 144; r.mode = 1; end
            4'b1000: begin r.ncbps = 288; ndb = 192; r.mode = 2; end
            4'b1100: begin r.ncbps = 288; ndb = 216; r.mode = 1; end
            default: r.status[1] = 1'b1;
        endcase
        if (v.resv || v.len == 0 || v.len > 4095) r.status[2] = 1'b1;
`ifdef RX_PARITY_CHECK_EN
        if (v.flip) r.status[0] = 1'b1;
`endif
        r.ok = (r.status == 3'b000);
        if (r.ok) begin
            tgt    = 22 + 8 * v.len;
            r.nsym = (tgt + ndb - 1) / ndb;
            r.npad = r.nsym * ndb - tgt;
        end else begin
            r.mode = 0; r.ncbps = 0;
        end
        return r;
    endfunction

    function automatic logic [23:0] make_sig(input vec_t v);
        logic [23:0] s;
        s       = 24'd0;
        s[3:0]  = v.rate;
        s[4]    = v.resv;
        s[16:5] = v.len[11:0];
        s[17]   = (^s[16:0]) ^ v.flip;
        return s;
    endfunction

    task automatic send_bit(input logic b, input bit stall);
        if (stall && ($urandom_range(0, 7) == 0)) begin
            enable   = 1'b0;
            rx_valid = 1'($urandom);
            rx_bit   = 1'($urandom);
            repeat ($urandom_range(1, 3)) tick();
            enable   = 1'b1;
        end
        rx_valid = 1'b1;
        rx_bit   = b;
        tick();
    endtask

    task automatic send_payload(input int n, input bit stall);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom);
            sent.push_back(b);
            send_bit(b, stall);
        end
    endtask

    task automatic start_frame(input vec_t v, input bit stall);
        logic [23:0] s;
        pv_base = rx_q.size();
        fd_base = fd_cnt;
        fa_base = fa_cnt;
        sent.delete();
        s = make_sig(v);
        for (int i = 0; i < PRE; i++) send_bit(1'($urandom), stall);
        for (int i = 0; i < 24; i++) send_bit(s[i], stall);
    endtask

    task automatic check_payload(input string tag);
        int n;
        int errs;
        n    = rx_q.size() - pv_base;
        errs = 0;
        for (int i = 0; i < n && i < sent.size(); i++)
            if (rx_q[pv_base + i] !== sent[i]) errs++;
        check({tag, "_count"}, n, sent.size());
        check({tag, "_data"}, errs, 0);
    endtask

    task automatic run_frame(input vec_t v, input bit stall);
        logic [34:0] exp_rv;
        start_frame(v, stall);
        check("hdr_valid", hdr_valid, v.ok);
        check("hdr_error", hdr_error, !v.ok);
        check("hdr_status", hdr_status, v.status);
        if (v.ok) begin
            exp_rv = {v.len[11:0], 3'b000, v.rate, 16'h0000};
            check("mode", mode, v.mode);
            check("rxvector", rxvector, exp_rv);
            send_payload(v.nsym * v.ncbps, stall);
            check("drain_read_en", dec_read_en, 1);
            send_bit(1'($urandom), stall);
            rx_valid = 1'b0;
            repeat (3) tick();
            dec_done = 1'b1;
            tick();
            dec_done = 1'b0;
            check("frame_done", frame_done, 1);
            check("read_en_drop", dec_read_en, 0);
            check("n_sym", n_sym, v.nsym);
            check("n_pad", n_pad, v.npad);
            check_payload("payload");
        end else begin
            for (int i = 0; i < 5; i++) send_bit(1'($urandom), stall);
            check("err_busy", busy, 1);
            rx_valid = 1'b0;
            tick();
            check("err_idle", busy, 0);
            check_payload("err_payload");
        end
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   guard;
        vec_t v;

        tbl[0]  = '{4'b1011, 1,    0, 0, 1, 3'b000, 0, 48,  2,   18};
        tbl[1]  = '{4'b1100, 100,  0, 0, 1, 3'b000, 1, 288, 4,   42};
        tbl[2]  = '{4'b1111, 10,   0, 0, 1, 3'b000, 1, 48,  3,   6};
        tbl[3]  = '{4'b1010, 5,    0, 0, 1, 3'b000, 0, 96,  2,   34};
        tbl[4]  = '{4'b1000, 50,   0, 0, 1, 3'b000, 2, 288, 3,   154};
        tbl[5]  = '{4'b1110, 7,    0, 0, 1, 3'b000, 1, 96,  2,   66};
        tbl[6]  = '{4'b1001, 20,   0, 0, 1, 3'b000, 0, 192, 2,   10};
        tbl[7]  = '{4'b1101, 30,   0, 0, 1, 3'b000, 1, 192, 2,   26};
        tbl[8]  = '{4'b0111, 1,    0, 0, 0, 3'b010, 0, 0,   0,   0};
        tbl[9]  = '{4'b1011, 0,    0, 0, 0, 3'b100, 0, 0,   0,   0};
        tbl[10] = '{4'b1011, 3,    1, 0, 0, 3'b100, 0, 0,   0,   0};
`ifdef RX_PARITY_CHECK_EN
        tbl[11] = '{4'b1011, 1,    0, 1, 0, 3'b001, 0, 0,   0,   0};
`else
        tbl[11] = '{4'b1011, 1,    0, 1, 1, 3'b000, 0, 48,  2,   18};
`endif
        tbl[12] = '{4'b1100, 4095, 0, 0, 1, 3'b000, 1, 288, 152, 50};

        reset = 1'b1; enable = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0; dec_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_rxvector", rxvector, 0);
        check("reset_misc", {payload_bit, payload_valid, mode, dec_read_en, hdr_valid, hdr_error,
                             hdr_status, n_sym, n_pad, frame_done, frame_abort, busy}, 0);

        for (int i = 0; i < 13; i++) run_frame(tbl[i], 1'b0);

        // Abort after 50 payload bits (one symbol already wrapped), then a clean frame.
        start_frame(tbl[0], 1'b0);
        send_payload(50, 1'b0);
        rx_valid = 1'b0;
        tick();
        check("abort_pulse", frame_abort, 1);
        check("abort_busy", busy, 0);
        check("abort_pv", payload_valid, 0);
        check("abort_nsym", n_sym, 0);
        check_payload("abort_payload");
        tick();
        check("abort_one_cycle", frame_abort, 0);
        run_frame(tbl[0], 1'b0);

        // Drain without dec_done: timeout closes the frame and flags status[2].
        start_frame(tbl[0], 1'b0);
        send_payload(96, 1'b0);
        rx_valid = 1'b0;
        n = 0;
        guard = 0;
        while (!frame_done && guard < 3 * DRN) begin
            if (dec_read_en) n++;
            tick();
            guard++;
        end
        check("timeout_done", frame_done, 1);
        check("timeout_cycles", n, DRN);
        check("timeout_status", hdr_status, 3'b100);
        check("timeout_nsym", n_sym, 2);
        check("timeout_npad", n_pad, 18);
        tick();

        // Reset in the middle of a payload.
        start_frame(tbl[1], 1'b0);
        send_payload(20, 1'b0);
        reset    = 1'b1;
        rx_valid = 1'b0;
        #2;
        check("midrst_rxvector", rxvector, 0);
        check("midrst_misc", {payload_bit, payload_valid, mode, dec_read_en, hdr_valid, hdr_error,
                              hdr_status, n_sym, n_pad, frame_done, frame_abort, busy}, 0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_no_pulse", (fa_cnt - fa_base) + (fd_cnt - fd_base), 0);
        check("midrst_idle", busy, 0);

        // Randomized frames with enable stalls against the reference model.
        for (int k = 0; k < 10; k++) begin
            v.rate = ($urandom_range(0, 5) == 0) ? {1'b0, 3'($urandom)} : {1'b1, 3'($urandom)};
            v.len  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            v.resv = ($urandom_range(0, 9) == 0);
            v.flip = ($urandom_range(0, 9) == 0);
            v = model(v);
            run_frame(v, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
